// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexed common-anode seven-segment scanner with hex decode,
//            frame-synchronous double buffering, 16-level PWM brightness,
//            per-digit blank / decimal-point masks and a frame strobe.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_DIGITS   digits scanned (2..16)
//   REFRESH_DIV  clk cycles per digit slot (>=2)
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   i_value       hex nibbles, digit i = i_value[4i+3:4i], digit 0 rightmost
//   i_load        1-cycle strobe capturing value / blank mask / dp mask
//   i_blank_mask  1 = digit dark
//   i_dp_mask     1 = decimal point lit on that digit
//   i_brightness  PWM duty, digit lit while pwm counter <= brightness
//   o_seg         {g,f,e,d,c,b,a}, active-low
//   o_dp          decimal point, active-low
//   o_an          anodes, active-low, at most one low
//   o_pending     captured data not yet on display
//   o_frame_done  1-cycle pulse when the digit index wraps to 0
// Build option
//   LEADING_ZERO_BLANK_EN : suppress zero digits above the most significant
//                           non-zero nibble (digit 0 and dp digits excepted)
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic [3:0]              i_brightness,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_pending,
  output logic                    o_frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_start;
  logic                    w_slot_end;
  logic                    w_wrap;

  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [3:0]              r_pwm_cnt;

  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_blank;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pending;

  logic [NUM_DIGITS-1:0]   w_blank_eff;
  logic [3:0]              w_nib;
  logic                    w_dig_blank;
  logic                    w_dig_dp;
  logic                    w_on;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'b1000000;
      4'h1: f_hex = 7'b1111001;
      4'h2: f_hex = 7'b0100100;
      4'h3: f_hex = 7'b0110000;
      4'h4: f_hex = 7'b0011001;
      4'h5: f_hex = 7'b0010010;
      4'h6: f_hex = 7'b0000010;
      4'h7: f_hex = 7'b1111000;
      4'h8: f_hex = 7'b0000000;
      4'h9: f_hex = 7'b0010000;
      4'hA: f_hex = 7'b0001000;
      4'hB: f_hex = 7'b0000011;
      4'hC: f_hex = 7'b1000110;
      4'hD: f_hex = 7'b0100001;
      4'hE: f_hex = 7'b0000110;
      default: f_hex = 7'b0001110;
    endcase
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BLANK;
    else     r_state <= w_state_nxt;
  end

  // BLANK is only left by the first load; SCAN is only left by reset.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_slot_end  = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (i_load) begin
          w_state_nxt = ST_SCAN;
          w_start     = 1'b1;
        end
      end
      ST_SCAN: begin
        w_slot_end = (r_div_cnt == c_DIV_LAST);
        w_wrap     = w_slot_end && (r_idx == c_IDX_LAST);
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // ---------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
      r_pwm_cnt <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (w_start) begin
        r_div_cnt <= '0;
        r_idx     <= '0;
      end else if (r_state == ST_SCAN) begin
        if (w_slot_end) begin
          r_div_cnt <= '0;
          r_idx     <= w_wrap ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------- double buffering
  // The shadow copy drives the display; new data waits in the pending
  // copy until the frame wraps so a frame is never torn. A load landing on
  // the wrap cycle itself refills pending while the older data is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_val   <= '0;
      r_shadow_blank <= '0;
      r_shadow_dp    <= '0;
      r_pend_val     <= '0;
      r_pend_blank   <= '0;
      r_pend_dp      <= '0;
      r_pending      <= 1'b0;
    end else begin
      if (w_start) begin
        r_shadow_val   <= i_value;
        r_shadow_blank <= i_blank_mask;
        r_shadow_dp    <= i_dp_mask;
      end else if (w_wrap && r_pending) begin
        r_shadow_val   <= r_pend_val;
        r_shadow_blank <= r_pend_blank;
        r_shadow_dp    <= r_pend_dp;
      end

      if ((r_state == ST_SCAN) && i_load) begin
        r_pend_val   <= i_value;
        r_pend_blank <= i_blank_mask;
        r_pend_dp    <= i_dp_mask;
        r_pending    <= 1'b1;
      end else if (w_wrap) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------- blank masking
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_lz_keep;

  // Walk down from the top digit; once a non-zero nibble or a lit decimal
  // point is seen, that digit and everything below it stays visible.
  always_comb begin
    w_lz      = '0;
    w_lz_keep = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if ((r_shadow_val[4*i +: 4] != 4'h0) || r_shadow_dp[i]) w_lz_keep = 1'b1;
      w_lz[i] = ~w_lz_keep;
    end
  end

  assign w_blank_eff = r_shadow_blank | w_lz;
`else
  assign w_blank_eff = r_shadow_blank;
`endif

  // ------------------------------------------------- current digit mux
  always_comb begin
    w_nib       = 4'h0;
    w_dig_blank = 1'b0;
    w_dig_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_shadow_val[4*i +: 4];
        w_dig_blank = w_blank_eff[i];
        w_dig_dp    = r_shadow_dp[i];
      end
    end
  end

  assign w_on = (r_state == ST_SCAN) && !w_dig_blank && (r_pwm_cnt <= i_brightness);

  // --------------------------------------------------- output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_on) begin
        r_an  <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg <= f_hex(w_nib);
        r_dp  <= ~w_dig_dp;
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_an         = r_an;
  assign o_pending    = r_pending;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire
